// File: rtl/safe_softmax_max_sub.sv
// Row-max / subtract stage of the safe softmax: buffers one Q2.13 row while tracking
// its maximum, then streams sat(x - max) in arrival order so downstream exp sees x <= 0.
module safe_softmax_max_sub #(
  parameter int D_W     = 16,
  parameter int ROW_LEN = 16,
  parameter int CNT_W   = $clog2(ROW_LEN)
) (
  input  logic                  I_CLK,
  input  logic                  I_RST_N,
  input  logic                  I_VALID,
  input  logic signed [D_W-1:0] I_DATA,
  output logic                  O_READY,
  output logic                  O_VALID,
  output logic signed [D_W-1:0] O_DATA,
  output logic                  O_LAST,
  input  logic                  I_READY,
  output logic signed [D_W-1:0] O_ROW_MAX
);

  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(ROW_LEN - 1);
  localparam logic signed [D_W-1:0] D_MIN    = {1'b1, {(D_W-1){1'b0}}};

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        wr_cnt;
  logic [CNT_W-1:0]        rd_cnt;
  logic signed [D_W-1:0]   max_r;
  logic signed [D_W-1:0]   next_max;
  logic signed [D_W-1:0]   row_buf [ROW_LEN];
  logic                    in_fire;
  logic                    out_fire;

  // x - max is never positive, so the only possible overflow is below the minimum code.
  function automatic logic signed [D_W-1:0] sat_sub(input logic signed [D_W-1:0] a,
                                                    input logic signed [D_W-1:0] b);
    logic signed [D_W:0] diff;
    diff = {a[D_W-1], a} - {b[D_W-1], b};
    if (diff[D_W] && !diff[D_W-1])
      sat_sub = D_MIN;
    else
      sat_sub = diff[D_W-1:0];
  endfunction

  assign O_READY  = (state == LOAD);
  assign O_VALID  = (state == DRAIN);
  assign O_LAST   = O_VALID && (rd_cnt == LAST_IDX);
  assign O_DATA   = O_VALID ? sat_sub(row_buf[rd_cnt], max_r) : '0;
  assign in_fire  = I_VALID && O_READY;
  assign out_fire = O_VALID && I_READY;

  // The first element of a row seeds the max so a stale max never leaks across rows.
  assign next_max = ((wr_cnt == '0) || (I_DATA > max_r)) ? I_DATA : max_r;

  // Row storage carries no reset; its contents are only read after a full row load.
  always_ff @(posedge I_CLK) begin
    if (in_fire)
      row_buf[wr_cnt] <= I_DATA;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state     <= LOAD;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      max_r     <= D_MIN;
      O_ROW_MAX <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            max_r <= next_max;
            if (wr_cnt == LAST_IDX) begin
              wr_cnt    <= '0;
              state     <= DRAIN;
              O_ROW_MAX <= next_max;
            end else begin
              wr_cnt <= wr_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (O_LAST) begin
              rd_cnt <= '0;
              state  <= LOAD;
            end else begin
              rd_cnt <= rd_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_safe_softmax_max_sub.sv
// Directed and randomised scoreboard bench for safe_softmax_max_sub with ROW_LEN = 4.
module tb_safe_softmax_max_sub;

  localparam int RL = 4;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic [15:0] m;
  } exp_t;

  logic        I_CLK = 1'b0;
  logic        I_RST_N = 1'b0;
  logic        I_VALID = 1'b0;
  logic [15:0] I_DATA = '0;
  logic        I_READY = 1'b1;
  logic        O_READY, O_VALID, O_LAST;
  logic [15:0] O_DATA, O_ROW_MAX;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [15:0] mrow[$];
  bit          use_model = 1'b0;
  bit          bp_en = 1'b0;
  bit          gap_en = 1'b0;
  bit          per_en = 1'b0;
  bit          have_last = 1'b0;
  int          last_cyc = 0;
  bit          held_v = 1'b0;
  logic [15:0] held_d;
  logic        held_l;

  safe_softmax_max_sub #(.D_W(16), .ROW_LEN(RL)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_VALID(I_VALID), .I_DATA(I_DATA),
    .O_READY(O_READY), .O_VALID(O_VALID), .O_DATA(O_DATA), .O_LAST(O_LAST),
    .I_READY(I_READY), .O_ROW_MAX(O_ROW_MAX)
  );

  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Independent reference: integer subtraction clamped at -32768.
  task automatic model_row();
    logic [15:0] mx;
    int          dv;
    exp_t        e;
    mx = mrow[0];
    for (int i = 1; i < RL; i++)
      if ($signed(mrow[i]) > $signed(mx)) mx = mrow[i];
    for (int i = 0; i < RL; i++) begin
      dv = int'($signed(mrow[i])) - int'($signed(mx));
      if (dv < -32768) dv = -32768;
      e.d = dv[15:0];
      e.l = (i == RL - 1);
      e.m = mx;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_exp(input logic [15:0] d[RL], input logic [15:0] mx);
    exp_t e;
    for (int i = 0; i < RL; i++) begin
      e.d = d[i];
      e.l = (i == RL - 1);
      e.m = mx;
      exp_q.push_back(e);
    end
  endtask

  task automatic put(input logic [15:0] d);
    bit ok;
    int n;
    n = 0;
    I_VALID = 1'b1;
    I_DATA  = d;
    do begin
      @(negedge I_CLK);
      ok = O_READY;
      @(posedge I_CLK);
      #1;
      n++;
    end while (!ok && n < 200);
    chk("accept_timeout", {15'b0, ok}, 16'd1);
    if (ok) begin
      mrow.push_back(d);
      if (mrow.size() == RL) begin
        if (use_model) model_row();
        chk("first_valid_latency", {15'b0, O_VALID}, 16'd1);
        mrow.delete();
      end
    end
  endtask

  task automatic load_row(input logic [15:0] v[RL]);
    for (int i = 0; i < RL; i++) begin
      if (gap_en) begin
        repeat ($urandom_range(0, 2)) begin
          I_VALID = 1'b0;
          @(posedge I_CLK);
          #1;
        end
      end
      put(v[i]);
    end
    I_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !O_READY) && n < 300) begin
      @(posedge I_CLK);
      #1;
      n++;
    end
    chk("drain_timeout", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic do_reset();
    I_VALID = 1'b0;
    I_RST_N = 1'b0;
    #1;
    chk("rst_ready", {15'b0, O_READY}, 16'd1);
    chk("rst_valid", {15'b0, O_VALID}, 16'd0);
    chk("rst_last", {15'b0, O_LAST}, 16'd0);
    chk("rst_data", O_DATA, 16'h0000);
    chk("rst_rowmax", O_ROW_MAX, 16'h0000);
    exp_q.delete();
    mrow.delete();
    held_v = 1'b0;
    @(posedge I_CLK);
    #1;
    I_RST_N = 1'b1;
  endtask

  // Output monitor: scoreboard pop on each transfer, stall stability, phase exclusivity.
  initial begin
    exp_t e;
    forever begin
      @(negedge I_CLK);
      if (I_RST_N) begin
        if (held_v) begin
          chk("stall_valid", {15'b0, O_VALID}, 16'd1);
          chk("stall_data", O_DATA, held_d);
          chk("stall_last", {15'b0, O_LAST}, {15'b0, held_l});
        end
        if (O_VALID) chk("ready_in_drain", {15'b0, O_READY}, 16'd0);
        if (O_VALID && I_READY) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", {15'b0, O_VALID}, 16'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", O_DATA, e.d);
            chk("out_last", {15'b0, O_LAST}, {15'b0, e.l});
            chk("out_rowmax", O_ROW_MAX, e.m);
            if (e.l) begin
              if (per_en && have_last) chk("row_period", 16'(cyc - last_cyc), 16'd8);
              last_cyc  = cyc;
              have_last = 1'b1;
            end
          end
        end
        held_v = O_VALID && !I_READY;
        held_d = O_DATA;
        held_l = O_LAST;
      end
    end
  end

  initial begin
    forever begin
      @(posedge I_CLK);
      #1;
      I_READY = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    logic [15:0] v[RL];
    #2;
    chk("init_ready", {15'b0, O_READY}, 16'd1);
    chk("init_valid", {15'b0, O_VALID}, 16'd0);
    chk("init_last", {15'b0, O_LAST}, 16'd0);
    chk("init_data", O_DATA, 16'h0000);
    chk("init_rowmax", O_ROW_MAX, 16'h0000);
    @(posedge I_CLK);
    #1;
    I_RST_N = 1'b1;

    // Basic row
    push_exp('{16'hE000, 16'hC000, 16'hA000, 16'h0000}, 16'h4000);
    load_row('{16'h2000, 16'h0000, 16'hE000, 16'h4000});
    wait_drain();
    chk("rowmax_hold", O_ROW_MAX, 16'h4000);

    // Saturation
    push_exp('{16'h0000, 16'h8000, 16'h8001, 16'h0000}, 16'h7FFF);
    load_row('{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF});
    wait_drain();

    // All equal, then all negative
    push_exp('{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hC000);
    load_row('{16'hC000, 16'hC000, 16'hC000, 16'hC000});
    wait_drain();
    push_exp('{16'hA000, 16'hB000, 16'h9000, 16'h0000}, 16'hF000);
    load_row('{16'h9000, 16'hA000, 16'h8000, 16'hF000});
    wait_drain();
    chk("rowmax_neg_hold", O_ROW_MAX, 16'hF000);

    // Reset after 2 of 4 inputs, then a clean row
    use_model = 1'b1;
    put(16'h1234);
    put(16'h7000);
    I_VALID = 1'b0;
    do_reset();
    load_row('{16'h0100, 16'hFF00, 16'h0200, 16'h8000});
    wait_drain();

    // Reset mid-drain after 2 outputs, then a clean row
    load_row('{16'h3000, 16'h1000, 16'hD000, 16'h0800});
    begin
      int n;
      n = 0;
      while (exp_q.size() > 2 && n < 50) begin
        @(posedge I_CLK);
        #1;
        n++;
      end
      chk("mid_drain_pending", 16'(exp_q.size()), 16'd2);
    end
    do_reset();
    load_row('{16'hF800, 16'h0400, 16'h0400, 16'hC000});
    wait_drain();

    // Back-to-back rows, no gaps, no backpressure
    per_en    = 1'b1;
    have_last = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < RL; i++) v[i] = 16'($urandom);
      load_row(v);
    end
    wait_drain();
    per_en = 1'b0;

    // Random gaps and backpressure over 50 rows
    bp_en  = 1'b1;
    gap_en = 1'b1;
    for (int r = 0; r < 50; r++) begin
      for (int i = 0; i < RL; i++) begin
        case ($urandom_range(0, 5))
          0:       v[i] = 16'h7FFF;
          1:       v[i] = 16'h8000;
          default: v[i] = 16'($urandom);
        endcase
      end
      load_row(v);
    end
    wait_drain();
    bp_en  = 1'b0;
    gap_en = 1'b0;

    repeat (2) @(posedge I_CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
